// File: rtl/axi_wr_burst_pack.sv
// axi_wr_burst_pack: buffers packed words from an upstream combiner in a FIFO
// and writes them out as AXI write bursts of up to BURST_LEN beats, walking a
// frame address pointer from BASE_ADDR. One burst is outstanding at a time.
// End-of-frame requests flush the remainder as a short burst and pulse
// frame_done once the final response returns.
module axi_wr_burst_pack #(
    parameter int              DSIZE     = 256,
    parameter int              BURST_LEN = 16,
    parameter int              DEPTH     = 32,
    parameter int              AW        = 32,
    parameter logic [AW-1:0]   BASE_ADDR = '0
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 iwr_en,
    input  logic [DSIZE-1:0]     idata,
    input  logic [DSIZE/8-1:0]   imask,
    input  logic                 ilast_en,
    input  logic                 ifsync,
    output logic [AW-1:0]        awaddr,
    output logic [7:0]           awlen,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [DSIZE-1:0]     wdata,
    output logic [DSIZE/8-1:0]   wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready,
    output logic                 frame_done,
    output logic                 overflow,
    output logic                 resp_err
);

    localparam int              MW         = DSIZE / 8;
    localparam int              PW         = $clog2(DEPTH);
    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   BURST_C    = CW'(BURST_LEN);
    localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
    localparam logic [AW-1:0]   BEAT_BYTES = AW'(MW);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t              state;

    // FIFO storage and bookkeeping; entries are {mask, data}
    logic [MW+DSIZE-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                full;
    logic                push;
    logic                pop;

    // Burst bookkeeping
    logic [CW-1:0]       beats;
    logic [CW-1:0]       beat_cnt;
    logic                final_burst;
    logic                flush_pending;
    logic                sync_pending;
    logic [AW-1:0]       addr_ptr;

    // IDLE-state decisions
    logic                launch;
    logic                launch_final;
    logic                empty_flush;
    logic [CW-1:0]       launch_beats;
    logic [AW-1:0]       launch_addr;

    assign full  = (count == DEPTH_C);
    assign pop   = wvalid && wready;
    // A word arriving on a full FIFO still fits if the head leaves this cycle.
    assign push  = iwr_en && (!full || pop);

    assign {wstrb, wdata} = mem[rd_ptr];

    assign launch       = (count >= BURST_C) || (flush_pending && (count != '0));
    assign launch_beats = (count >= BURST_C) ? BURST_C : count;
    assign launch_final = flush_pending && (count <= BURST_C);
    // Frame end with nothing buffered and nothing arriving: finish without bus traffic.
    assign empty_flush  = (count == '0) && !iwr_en && (flush_pending || ilast_en);
    assign launch_addr  = ifsync ? BASE_ADDR : addr_ptr;

    // Word storage write port
    // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {imask, idata};
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag
    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (iwr_en && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Burst sequencer: address phase, data beats, response, pointer advance
    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= IDLE;
            awvalid       <= 1'b0;
            awaddr        <= '0;
            awlen         <= '0;
            wvalid        <= 1'b0;
            wlast         <= 1'b0;
            bready        <= 1'b0;
            frame_done    <= 1'b0;
            resp_err      <= 1'b0;
            beats         <= '0;
            beat_cnt      <= '0;
            final_burst   <= 1'b0;
            flush_pending <= 1'b0;
            sync_pending  <= 1'b0;
            addr_ptr      <= BASE_ADDR;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    addr_ptr <= launch_addr;
                    if (launch) begin
                        state       <= ADDR;
                        awvalid     <= 1'b1;
                        awaddr      <= launch_addr;
                        awlen       <= 8'(launch_beats - CW'(1));
                        beats       <= launch_beats;
                        beat_cnt    <= '0;
                        final_burst <= launch_final;
                        if (launch_final) begin
                            flush_pending <= 1'b0;
                        end
                    end else if (empty_flush) begin
                        frame_done    <= 1'b1;
                        flush_pending <= 1'b0;
                    end
                end
                ADDR: begin
                    if (ifsync) begin
                        sync_pending <= 1'b1;
                    end
                    if (awready) begin
                        awvalid <= 1'b0;
                        state   <= DATA;
                        // Beats only go out once the whole burst is buffered.
                        wvalid  <= (count >= beats);
                        wlast   <= (beats == CW'(1));
                    end
                end
                DATA: begin
                    if (ifsync) begin
                        sync_pending <= 1'b1;
                    end
                    if (!wvalid) begin
                        if (count >= beats) begin
                            wvalid <= 1'b1;
                        end
                    end else if (wready) begin
                        if (beat_cnt == beats - CW'(1)) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= RESP;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                            wlast    <= (beat_cnt + CW'(2) == beats);
                        end
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        bready       <= 1'b0;
                        state        <= IDLE;
                        sync_pending <= 1'b0;
                        if (bresp != 2'b00) begin
                            resp_err <= 1'b1;
                        end
                        if (final_burst) begin
                            frame_done <= 1'b1;
                        end
                        // A frame sync seen during the burst replaces the normal advance.
                        if (sync_pending || ifsync) begin
                            addr_ptr <= BASE_ADDR;
                        end else begin
                            addr_ptr <= addr_ptr + AW'(beats) * BEAT_BYTES;
                        end
                    end else if (ifsync) begin
                        sync_pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Repeated end-of-frame requests merge into the one already pending.
            if (ilast_en && !flush_pending && !((state == IDLE) && empty_flush)) begin
                flush_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_pack.sv
// tb_axi_wr_burst_pack: directed bench for axi_wr_burst_pack with a small
// configuration (32-bit beats, 4-beat bursts, 8-entry FIFO, frame at 0x1000).
// A cycle table covers the empty flush and a short flushed burst; hand-written
// sequences cover full bursts, overflow, error responses, resync and reset.
module tb_axi_wr_burst_pack;

    localparam int          DSIZE     = 32;
    localparam int          BURST_LEN = 4;
    localparam int          DEPTH     = 8;
    localparam int          AW        = 32;
    localparam logic [31:0] BASE      = 32'h1000;

    logic        clock = 1'b0;
    logic        rst;
    logic        iwr_en;
    logic [31:0] idata;
    logic [3:0]  imask;
    logic        ilast_en;
    logic        ifsync;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        frame_done;
    logic        overflow;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    axi_wr_burst_pack #(
        .DSIZE     (DSIZE),
        .BURST_LEN (BURST_LEN),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .iwr_en     (iwr_en),
        .idata      (idata),
        .imask      (imask),
        .ilast_en   (ilast_en),
        .ifsync     (ifsync),
        .awaddr     (awaddr),
        .awlen      (awlen),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .frame_done (frame_done),
        .overflow   (overflow),
        .resp_err   (resp_err)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        last;
        logic        sync;
        logic        awr;
        logic        wrdy;
        logic        bv;
        logic [1:0]  br;
    } in_t;

    typedef struct packed {
        logic        awv;
        logic [31:0] addr;
        logic [7:0]  len;
        logic        wv;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        wl;
        logic        br;
        logic        fd;
        logic        ovf;
        logic        rerr;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    // Handshake log rebuilt after every reset
    logic [39:0] aw_q[$];
    logic [32:0] w_q[$];
    int          b_cnt;
    int          fd_cnt;
    int          fd_at_b;

    // Records every AXI handshake and frame_done pulse seen at the clock edge
    always @(posedge clock) begin
        if (rst) begin
            aw_q.delete();
            w_q.delete();
            b_cnt   <= 0;
            fd_cnt  <= 0;
            fd_at_b <= 0;
        end else begin
            if (awvalid && awready) aw_q.push_back({awaddr, awlen});
            if (wvalid && wready)   w_q.push_back({wlast, wdata});
            if (bready && bvalid)   b_cnt <= b_cnt + 1;
            if (frame_done) begin
                fd_cnt  <= fd_cnt + 1;
                fd_at_b <= b_cnt;
            end
        end
    end

    // Hard stop in case a sequence wedges outside the bounded waits
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, {96'b0, act}, {96'b0, exp});
    endtask

    function automatic in_t vi(logic wr, logic [31:0] d, logic [3:0] m, logic last,
                               logic awr, logic wrdy, logic bv);
        in_t r;
        r = '{wr: wr, data: d, mask: m, last: last, sync: 1'b0,
              awr: awr, wrdy: wrdy, bv: bv, br: 2'b00};
        return r;
    endfunction

    function automatic out_t vo(logic awv, logic [31:0] addr, logic [7:0] len, logic wv,
                                logic [31:0] wd, logic [3:0] ws, logic wl, logic br, logic fd);
        out_t r;
        r = '{awv: awv, addr: addr, len: len, wv: wv, wd: wd, ws: ws,
              wl: wl, br: br, fd: fd, ovf: 1'b0, rerr: 1'b0};
        return r;
    endfunction

    // Address fields only matter while awvalid, data fields only while wvalid.
    function automatic out_t mask_out(out_t o);
        out_t r;
        r = o;
        if (!r.awv) begin
            r.addr = '0;
            r.len  = '0;
        end
        if (!r.wv) begin
            r.wd = '0;
            r.ws = '0;
        end
        return r;
    endfunction

    function automatic out_t act_out();
        out_t r;
        r = '{awv: awvalid, addr: awaddr, len: awlen, wv: wvalid, wd: wdata, ws: wstrb,
              wl: wlast, br: bready, fd: frame_done, ovf: overflow, rerr: resp_err};
        return mask_out(r);
    endfunction

    // NOTE: inputs change on the falling edge with blocking assignments, so the DUT samples settled values.
    task automatic do_reset();
        @(negedge clock);
        rst      = 1'b1;
        iwr_en   = 1'b0;
        idata    = '0;
        imask    = '0;
        ilast_en = 1'b0;
        ifsync   = 1'b0;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        bresp    = 2'b00;
        repeat (2) @(negedge clock);
        rst = 1'b0;
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            iwr_en = 1'b1;
            idata  = base + 32'(i);
            imask  = 4'hF;
            @(negedge clock);
        end
        iwr_en = 1'b0;
    endtask

    task automatic pulse_last();
        ilast_en = 1'b1;
        @(negedge clock);
        ilast_en = 1'b0;
    endtask

    task automatic wait_b(input int n, input string name);
        int k;
        k = 0;
        while (b_cnt < n && k < 300) begin
            @(negedge clock);
            k++;
        end
        check32(name, 32'(b_cnt >= n), 32'd1);
    endtask

    task automatic wait_fd(input int n, input string name);
        int k;
        k = 0;
        while (fd_cnt < n && k < 300) begin
            @(negedge clock);
            k++;
        end
        check32(name, 32'(fd_cnt >= n), 32'd1);
    endtask

    task automatic wait_awvalid(input string name);
        int k;
        k = 0;
        while (!awvalid && k < 100) begin
            @(negedge clock);
            k++;
        end
        check32(name, 32'(awvalid), 32'd1);
    endtask

    task automatic wait_wvalid(input string name);
        int k;
        k = 0;
        while (!wvalid && k < 100) begin
            @(negedge clock);
            k++;
        end
        check32(name, 32'(wvalid), 32'd1);
    endtask

    initial begin
        logic seen;

        // Cycle table: each row holds the outputs expected at the start of the
        // cycle and the inputs driven during it.
        // Empty flush, then two words + flush -> one 2-beat final burst at BASE.
        vecs[0]  = '{vi(0, 32'h0,  4'h0, 1, 0, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{vi(0, 32'h0,  4'h0, 0, 0, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vecs[2]  = '{vi(1, 32'hA1, 4'hF, 0, 0, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{vi(1, 32'hA2, 4'h3, 1, 0, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{vi(0, 32'h0,  4'h0, 0, 0, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{vi(0, 32'h0,  4'h0, 0, 0, 0, 0), vo(1, BASE, 1, 0, 0, 0, 0, 0, 0)};
        vecs[6]  = '{vi(0, 32'h0,  4'h0, 0, 1, 0, 0), vo(1, BASE, 1, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{vi(0, 32'h0,  4'h0, 0, 0, 0, 0), vo(0, 0, 0, 1, 32'hA1, 4'hF, 0, 0, 0)};
        vecs[8]  = '{vi(0, 32'h0,  4'h0, 0, 0, 1, 0), vo(0, 0, 0, 1, 32'hA1, 4'hF, 0, 0, 0)};
        vecs[9]  = '{vi(0, 32'h0,  4'h0, 0, 0, 1, 0), vo(0, 0, 0, 1, 32'hA2, 4'h3, 1, 0, 0)};
        vecs[10] = '{vi(0, 32'h0,  4'h0, 0, 0, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        vecs[11] = '{vi(0, 32'h0,  4'h0, 0, 0, 0, 1), vo(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        vecs[12] = '{vi(0, 32'h0,  4'h0, 0, 0, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vecs[13] = '{vi(0, 32'h0,  4'h0, 0, 0, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0)};

        do_reset();
        for (int i = 0; i < NV; i++) begin
            check($sformatf("vec%0d", i), {45'b0, act_out()}, {45'b0, mask_out(vecs[i].o)});
            {iwr_en, idata, imask, ilast_en, ifsync, awready, wready, bvalid, bresp} = vecs[i].i;
            @(negedge clock);
        end

        // Eight words, slaves always ready: two full bursts
        do_reset();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        push_words(8, 32'h100);
        wait_b(2, "two_bursts_resp");
        check32("two_bursts_aw_count", aw_q.size(), 32'd2);
        check32("two_bursts_addr0", aw_q[0][39:8], 32'h1000);
        check32("two_bursts_len0", 32'(aw_q[0][7:0]), 32'd3);
        check32("two_bursts_addr1", aw_q[1][39:8], 32'h1010);
        check32("two_bursts_len1", 32'(aw_q[1][7:0]), 32'd3);
        check32("two_bursts_beats", w_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check32($sformatf("two_bursts_data%0d", i), w_q[i][31:0], 32'h100 + 32'(i));
            check32($sformatf("two_bursts_last%0d", i), 32'(w_q[i][32]), 32'((i % 4) == 3));
        end
        check32("two_bursts_no_overflow", 32'(overflow), 32'd0);

        // Six words then end of frame (pulsed twice): full + 2-beat burst, one frame_done
        do_reset();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        push_words(6, 32'h200);
        pulse_last();
        @(negedge clock);
        pulse_last();
        wait_fd(1, "flush_frame_done");
        repeat (6) @(negedge clock);
        check32("flush_fd_count", fd_cnt, 32'd1);
        check32("flush_fd_after_resp", fd_at_b, 32'd2);
        check32("flush_aw_count", aw_q.size(), 32'd2);
        check32("flush_addr0", aw_q[0][39:8], 32'h1000);
        check32("flush_len0", 32'(aw_q[0][7:0]), 32'd3);
        check32("flush_addr1", aw_q[1][39:8], 32'h1010);
        check32("flush_len1", 32'(aw_q[1][7:0]), 32'd1);
        check32("flush_beats", w_q.size(), 32'd6);
        check32("flush_tail_beat", {w_q[5][32], w_q[5][30:0]}, {1'b1, 31'h205});

        // wready low: ninth word dropped; then push during pop while full is kept
        do_reset();
        awready = 1'b1; bvalid = 1'b1;
        push_words(8, 32'h300);
        check32("ovf_before_drop", 32'(overflow), 32'd0);
        push_words(1, 32'h3FF);
        check32("ovf_after_drop", 32'(overflow), 32'd1);
        check32("ovf_stall_wvalid", 32'(wvalid), 32'd1);
        wready = 1'b1;
        iwr_en = 1'b1; idata = 32'h310; imask = 4'hF;
        @(negedge clock);
        iwr_en = 1'b0;
        wait_b(2, "ovf_drain_resp");
        pulse_last();
        wait_fd(1, "ovf_frame_done");
        check32("ovf_beats", w_q.size(), 32'd9);
        for (int i = 0; i < 8; i++) begin
            check32($sformatf("ovf_data%0d", i), w_q[i][31:0], 32'h300 + 32'(i));
        end
        check32("ovf_full_push_beat", {w_q[8][32], w_q[8][30:0]}, {1'b1, 31'h310});
        check32("ovf_last_len", 32'(aw_q[2][7:0]), 32'd0);
        check32("ovf_sticky", 32'(overflow), 32'd1);

        // SLVERR on the first response: sticky error, addressing continues
        do_reset();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        push_words(4, 32'h400);
        wait_b(1, "err_first_resp");
        bresp = 2'b00;
        check32("err_set", 32'(resp_err), 32'd1);
        push_words(8, 32'h410);
        wait_b(3, "err_later_resp");
        check32("err_sticky", 32'(resp_err), 32'd1);
        check32("err_addr1", aw_q[1][39:8], 32'h1010);
        check32("err_addr2", aw_q[2][39:8], 32'h1020);

        // Frame sync during the data phase of the 0x1010 burst
        do_reset();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        push_words(4, 32'h500);
        wait_b(1, "sync_first_resp");
        wready = 1'b0;
        push_words(4, 32'h510);
        wait_wvalid("sync_in_data");
        ifsync = 1'b1;
        @(negedge clock);
        ifsync = 1'b0;
        wready = 1'b1;
        wait_b(2, "sync_second_resp");
        push_words(4, 32'h520);
        wait_b(3, "sync_third_resp");
        check32("sync_addr1", aw_q[1][39:8], 32'h1010);
        check32("sync_addr2", aw_q[2][39:8], 32'h1000);

        // Reset in the middle of an address phase abandons the burst
        do_reset();
        push_words(4, 32'h600);
        wait_awvalid("rst_mid_aw");
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            seen = seen | awvalid | wvalid | bready | frame_done;
            @(negedge clock);
        end
        check32("rst_mid_quiet", 32'(seen), 32'd0);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        push_words(4, 32'h610);
        wait_b(1, "rst_mid_resume");
        check32("rst_mid_addr", aw_q[0][39:8], 32'h1000);
        check32("rst_mid_data", w_q[0][31:0], 32'h610);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_wr_burst_pack.md
AXI_WR_BURST_PACK -- requirements
Module: axi_wr_burst_pack

Interface
REQ-001 Parameters SHALL be: DSIZE, default 256, data beat width in bits (multiple of 8); BURST_LEN, default 16, maximum beats per burst (1..256); DEPTH, default 32, FIFO depth in beats (power of 2, at least 2*BURST_LEN); AW, default 32, address width; BASE_ADDR, default 0, frame start byte address.
REQ-002 Ports SHALL be, in order:
- clock  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- iwr_en  in  1  word valid from upstream combiner.
- idata  in  DSIZE  packed word.
- imask  in  DSIZE/8  byte-enable for idata.
- ilast_en  in  1  one-cycle flush request, end of frame.
- ifsync  in  1  one-cycle frame start; rewinds address to BASE_ADDR.
- awaddr  out  AW  burst byte address.
- awlen  out  8  beats minus one.
- awvalid  out  1  address valid.
- awready  in  1  address accept.
- wdata  out  DSIZE  write data.
- wstrb  out  DSIZE/8  write strobes.
- wlast  out  1  final beat of burst.
- wvalid  out  1  data valid.
- wready  in  1  data accept.
- bresp  in  2  write response code.
- bvalid  in  1  response valid.
- bready  out  1  response accept.
- frame_done  out  1  one-cycle pulse, frame fully written.
- overflow  out  1  sticky, a word was dropped.
- resp_err  out  1  sticky, non-OKAY response seen.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high on port rst.

Function
REQ-004 Words SHALL be stored {imask,idata} in a DEPTH-entry FIFO on each iwr_en cycle while FIFO is not full.
REQ-005 iwr_en while full SHALL drop the word, leave the FIFO unchanged and set overflow.
REQ-006 FSM states SHALL be IDLE, ADDR, DATA, RESP; only one burst outstanding.
REQ-007 IDLE->ADDR SHALL occur when count>=BURST_LEN, or when flush_pending and count>0.
- beats latched = min(count, BURST_LEN).
- awlen = beats-1.
- awaddr = current address pointer.
REQ-008 ADDR: awvalid high, other fields stable; on awready -> DATA.
REQ-009 DATA:
- wvalid high; wdata/wstrb from FIFO head.
- FIFO pops on wvalid&wready.
- wlast high only on the final latched beat.
- final beat accepted -> RESP.
REQ-010 RESP: bready high; on bvalid -> IDLE.
- address pointer += beats*DSIZE/8, modulo 2^AW.
- bresp!=0 sets resp_err.
REQ-011 DATA entry SHALL be gated on count>=beats; FIFO never underflows.
REQ-012 flush_pending SHALL set on ilast_en.
- clears when a burst launches with count<=BURST_LEN; that burst is marked final.
- frame_done pulses for one cycle on the final burst's bvalid handshake.
REQ-013 ilast_en with FIFO empty and FSM IDLE SHALL produce frame_done on the next cycle with no AXI traffic.
REQ-014 ilast_en arriving while flush_pending is already set SHALL be merged; only one frame_done results.
REQ-015 ifsync in IDLE SHALL load BASE_ADDR next cycle.
- ifsync outside IDLE is held pending and applied on return to IDLE, overriding that burst's increment.
REQ-016 Simultaneous push and pop SHALL leave count unchanged; push while full and popping SHALL be accepted.
REQ-017 awvalid and wvalid SHALL not drop before their handshake completes.

Reset
REQ-018 On rst high at a clock edge the block SHALL:
- clear FIFO pointers and count;
- enter IDLE;
- clear flush_pending and pending ifsync;
- load the address pointer with BASE_ADDR;
- drive awvalid, wvalid, wlast, bready, frame_done, overflow and resp_err to 0.
REQ-019 rst mid-burst SHALL abandon the burst immediately; no further AXI outputs are asserted until new data arrives.

Verification (DSIZE=32, BURST_LEN=4, DEPTH=8, BASE_ADDR=0x1000)
REQ-020 Push 8 words, slaves always ready -> two bursts awaddr 0x1000/0x1010, awlen=3, wlast on beat 4 each.
REQ-021 Push 6 words then ilast_en -> bursts awlen=3 @0x1000, awlen=1 @0x1010; one frame_done after second bvalid.
REQ-022 ilast_en with FIFO empty -> frame_done next cycle, awvalid stays 0.
REQ-023 wready held low, push 9 words -> 9th dropped, overflow=1, FIFO holds 8.
REQ-024 bresp=2'b10 on first burst -> resp_err=1 sticky; following bursts continue at +0x10.
REQ-025 ifsync during DATA of burst @0x1010 -> next burst awaddr=0x1000.
